// File: rtl/mem_stage_ls.sv
// MEM pipeline stage: load/store access to a data RAM over a req/ack handshake,
// with lane alignment, load extension, store byte enables, misalign and timeout detection.
module mem_stage_ls #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [ADDR_W-1:0]     pc_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [ALUOP_W-1:0]    aluop_o,
  output logic [ADDR_W-1:0]     pc_o,
  output logic                  mem_req_o,
  output logic [DATA_W/8-1:0]   mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_data_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  addr_err_o,
  output logic                  bus_err_o,
  output logic                  stallreq
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  ldata_q, ldata_d;
  logic               err_q, err_d;

  logic               is_load, is_store, is_half, is_word, misaligned;
  logic [OFF_W-1:0]   off;
  logic [DATA_W-1:0]  st_data;
  logic [LANES-1:0]   we_mask;

  assign off = mem_addr_i[OFF_W-1:0];

  // Shift the addressed lane down to bit 0, then extend to the full register width.
  function automatic logic [DATA_W-1:0] load_extend(input logic [3:0]        op,
                                                    input logic [DATA_W-1:0] rd,
                                                    input logic [OFF_W-1:0]  o);
    logic [DATA_W-1:0]  sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = rd >> {o, 3'b000};
    b  = $signed(sh[7:0]);
    h  = $signed(sh[15:0]);
    case (op)
      OP_LB:   return {{(DATA_W-8){b[7]}}, b};
      OP_LBU:  return {{(DATA_W-8){1'b0}}, sh[7:0]};
      OP_LH:   return {{(DATA_W-16){h[15]}}, h};
      OP_LHU:  return {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    is_load    = mem_op_i inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    is_store   = mem_op_i inside {OP_SB, OP_SH, OP_SW};
    is_half    = mem_op_i inside {OP_LH, OP_LHU, OP_SH};
    is_word    = mem_op_i inside {OP_LW, OP_SW};
    misaligned = (is_half && mem_addr_i[0]) || (is_word && (off != '0));
  end

  always_comb begin
    st_data = reg2_i;
    we_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      if (mem_op_i == OP_SB) st_data[8*k +: 8] = reg2_i[7:0];
      if (mem_op_i == OP_SH) st_data[8*k +: 8] = reg2_i[8*(k%2) +: 8];
    end
    case (mem_op_i)
      OP_SB:   we_mask = LANES'(1) << off;
      OP_SH:   we_mask = LANES'(3) << off;
      OP_SW:   we_mask = '1;
      default: we_mask = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ldata_d   = ldata_q;
    err_d     = err_q;
    stallreq  = 1'b0;
    mem_req_o = 1'b0;
    bus_err_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if ((is_load || is_store) && !misaligned) begin
          stallreq = 1'b1;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        stallreq  = 1'b1;
        mem_req_o = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (mem_ack_i) begin
          ldata_d = load_extend(mem_op_i, mem_rdata_i, off);
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_o = 1'b1;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ldata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
    end
  end

  // RAM-side signals only carry the access while it is outstanding.
  always_comb begin
    mem_addr_o = '0;
    mem_we_o   = '0;
    mem_data_o = '0;
    if (state_q == S_BUSY) begin
      mem_addr_o = {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      if (is_store) begin
        mem_we_o   = we_mask;
        mem_data_o = st_data;
      end
    end
  end

  assign addr_err_o = misaligned;
  assign pc_o       = pc_i;

  always_comb begin
    wd_o    = '0;
    wreg_o  = 1'b0;
    wdata_o = '0;
    aluop_o = '0;
    if (!rst) begin
      wd_o    = wd_i;
      aluop_o = aluop_i;
      wreg_o  = wreg_i && !misaligned && !((state_q == S_DONE) && err_q);
      wdata_o = ((state_q == S_DONE) && is_load) ? ldata_q : wdata_i;
    end
  end

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls: loads, stores, misalignment, timeout and reset mid-access.
module tb_mem_stage_ls;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i, wd_o;
  logic        wreg_i, wreg_o;
  logic [31:0] wdata_i, wdata_o;
  logic [7:0]  aluop_i, aluop_o;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, reg2_i, pc_i, pc_o;
  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_rdata_i;
  logic        mem_ack_i, addr_err_o, bus_err_o, stallreq;

  int checks = 0;
  int failures = 0;

  int          r_stalls, r_busy, r_berr, r_berr_at;
  logic [31:0] r_wdata, b_addr, b_data;
  logic [3:0]  b_we;
  logic        r_wreg, r_aerr, r_ok;

  mem_stage_ls #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .ALUOP_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .pc_i(pc_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .aluop_o(aluop_o), .pc_o(pc_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .addr_err_o(addr_err_o),
    .bus_err_o(bus_err_o), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one access, acking in BUSY cycle ack_at (0 = never), and records what was seen.
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] r2,
                        input int ack_at, input logic [31:0] rdata);
    mem_op_i = op; mem_addr_i = addr; reg2_i = r2; wreg_i = 1'b1; wdata_i = 32'h5555_AAAA;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    #1;
    r_stalls = 0; r_busy = 0; r_berr = 0; r_berr_at = 0; r_ok = 1'b0;
    r_wdata = '0; r_wreg = 1'b0; b_addr = '0; b_we = '0; b_data = '0;
    r_aerr = addr_err_o;
    for (int c = 0; c < 30; c++) begin
      if (mem_req_o) r_busy++;
      if (bus_err_o) begin r_berr++; r_berr_at = r_busy; end
      if (mem_req_o && r_busy == 1) begin b_addr = mem_addr_o; b_we = mem_we_o; b_data = mem_data_o; end
      if (mem_req_o && r_busy == ack_at) begin mem_ack_i = 1'b1; mem_rdata_i = rdata; end
      if (stallreq) r_stalls++;
      else begin r_wdata = wdata_o; r_wreg = wreg_o; r_ok = 1'b1; break; end
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      #1;
    end
    if (!r_ok) rst = 1'b1;
    tick();
    rst = 1'b0; mem_op_i = 4'd0; mem_ack_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h1234_5678; aluop_i = 8'h3C;
    mem_op_i = 4'd0; mem_addr_i = '0; reg2_i = '0; pc_i = 32'h0000_0400;
    mem_rdata_i = '0; mem_ack_i = 1'b0;
    tick(); tick();
    checks++; if (wreg_o !== 1'b0) begin failures++; $display("FAIL rst_wreg got %b want 0", wreg_o); end
    checks++; if (wdata_o !== 32'h0) begin failures++; $display("FAIL rst_wdata got %h want 0", wdata_o); end
    checks++; if (wd_o !== 5'd0 || aluop_o !== 8'h0) begin failures++; $display("FAIL rst_wd_aluop got %h/%h want 0/0", wd_o, aluop_o); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got %b want 0", mem_req_o); end
    rst = 1'b0;
    #1;
    checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL rst_stall got %b want 0", stallreq); end
  endtask

  task automatic test_passthrough();
    mem_op_i = 4'd0; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hA5A5_0F0F; aluop_i = 8'h21; pc_i = 32'h0000_0800;
    #1;
    checks++; if (wd_o !== 5'd9 || aluop_o !== 8'h21 || pc_o !== 32'h0000_0800) begin failures++; $display("FAIL pass_fields got %h/%h/%h want 09/21/00000800", wd_o, aluop_o, pc_o); end
    checks++; if (wdata_o !== 32'hA5A5_0F0F || wreg_o !== 1'b1) begin failures++; $display("FAIL pass_wb got %h/%b want a5a50f0f/1", wdata_o, wreg_o); end
    checks++; if (stallreq !== 1'b0 || mem_req_o !== 1'b0) begin failures++; $display("FAIL pass_stall got %b/%b want 0/0", stallreq, mem_req_o); end
    mem_op_i = 4'hC;
    #1;
    checks++; if (stallreq !== 1'b0 || addr_err_o !== 1'b0) begin failures++; $display("FAIL pass_badop got %b/%b want 0/0", stallreq, addr_err_o); end
    tick();
    mem_op_i = 4'd0;
  endtask

  task automatic test_lw();
    access(4'd5, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
    checks++; if (r_stalls !== 4) begin failures++; $display("FAIL lw_stalls got %0d want 4", r_stalls); end
    checks++; if (b_we !== 4'b0000 || b_addr !== 32'h0000_0100) begin failures++; $display("FAIL lw_bus got %b/%h want 0000/00000100", b_we, b_addr); end
    checks++; if (r_wdata !== 32'hDEAD_BEEF || r_wreg !== 1'b1) begin failures++; $display("FAIL lw_wb got %h/%b want deadbeef/1", r_wdata, r_wreg); end
    checks++; if (r_busy !== 3 || r_berr !== 0) begin failures++; $display("FAIL lw_busy got %0d/%0d want 3/0", r_busy, r_berr); end
  endtask

  task automatic test_load_ext();
    access(4'd1, 32'h0000_0103, 32'h0, 1, 32'h8011_2233);
    checks++; if (r_wdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb got %h want ffffff80", r_wdata); end
    checks++; if (r_stalls !== 2) begin failures++; $display("FAIL lb_min_latency got %0d want 2", r_stalls); end
    access(4'd2, 32'h0000_0103, 32'h0, 1, 32'h8011_2233);
    checks++; if (r_wdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu got %h want 00000080", r_wdata); end
    access(4'd3, 32'h0000_0102, 32'h0, 2, 32'h8011_2233);
    checks++; if (r_wdata !== 32'hFFFF_8011) begin failures++; $display("FAIL lh got %h want ffff8011", r_wdata); end
    access(4'd4, 32'h0000_0102, 32'h0, 1, 32'h8011_2233);
    checks++; if (r_wdata !== 32'h0000_8011) begin failures++; $display("FAIL lhu got %h want 00008011", r_wdata); end
    access(4'd1, 32'h0000_0101, 32'h0, 1, 32'h8011_2233);
    checks++; if (r_wdata !== 32'h0000_0022) begin failures++; $display("FAIL lb_pos got %h want 00000022", r_wdata); end
  endtask

  task automatic test_store();
    access(4'd7, 32'h0000_0102, 32'h0000_ABCD, 1, 32'h0);
    checks++; if (b_data !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_data got %h want abcdabcd", b_data); end
    checks++; if (b_we !== 4'b1100 || b_addr !== 32'h0000_0100) begin failures++; $display("FAIL sh_we_addr got %b/%h want 1100/00000100", b_we, b_addr); end
    checks++; if (r_wdata !== 32'h5555_AAAA || r_wreg !== 1'b1) begin failures++; $display("FAIL sh_wb got %h/%b want 5555aaaa/1", r_wdata, r_wreg); end
    access(4'd6, 32'h0000_0101, 32'h1234_5677, 1, 32'h0);
    checks++; if (b_data !== 32'h7777_7777 || b_we !== 4'b0010) begin failures++; $display("FAIL sb got %h/%b want 77777777/0010", b_data, b_we); end
    access(4'd8, 32'h0000_0104, 32'hCAFE_F00D, 2, 32'h0);
    checks++; if (b_data !== 32'hCAFE_F00D || b_we !== 4'b1111 || b_addr !== 32'h0000_0104) begin failures++; $display("FAIL sw got %h/%b/%h want cafef00d/1111/00000104", b_data, b_we, b_addr); end
    checks++; if (r_stalls !== 3) begin failures++; $display("FAIL sw_stalls got %0d want 3", r_stalls); end
  endtask

  task automatic test_misaligned();
    mem_op_i = 4'd5; mem_addr_i = 32'h0000_0101; wreg_i = 1'b1;
    #1;
    checks++; if (addr_err_o !== 1'b1 || stallreq !== 1'b0) begin failures++; $display("FAIL mis_lw got err=%b stall=%b want 1/0", addr_err_o, stallreq); end
    checks++; if (wreg_o !== 1'b0 || mem_req_o !== 1'b0) begin failures++; $display("FAIL mis_lw_wb got wreg=%b req=%b want 0/0", wreg_o, mem_req_o); end
    tick();
    checks++; if (mem_req_o !== 1'b0 || stallreq !== 1'b0) begin failures++; $display("FAIL mis_lw_next got req=%b stall=%b want 0/0", mem_req_o, stallreq); end
    mem_op_i = 4'd3; mem_addr_i = 32'h0000_0103;
    #1;
    checks++; if (addr_err_o !== 1'b1) begin failures++; $display("FAIL mis_lh got %b want 1", addr_err_o); end
    mem_op_i = 4'd6; mem_addr_i = 32'h0000_0103;
    #1;
    checks++; if (addr_err_o !== 1'b0 || stallreq !== 1'b1) begin failures++; $display("FAIL sb_odd_ok got err=%b stall=%b want 0/1", addr_err_o, stallreq); end
    mem_op_i = 4'd0;
    tick();
  endtask

  task automatic test_timeout();
    access(4'd8, 32'h0000_0200, 32'h0BAD_F00D, 0, 32'h0);
    checks++; if (r_berr !== 1 || r_berr_at !== 4) begin failures++; $display("FAIL to_pulse got count=%0d at=%0d want 1/4", r_berr, r_berr_at); end
    checks++; if (r_stalls !== 5 || r_busy !== 4) begin failures++; $display("FAIL to_stalls got %0d/%0d want 5/4", r_stalls, r_busy); end
    checks++; if (r_ok !== 1'b1 || r_wreg !== 1'b0) begin failures++; $display("FAIL to_done got ok=%b wreg=%b want 1/0", r_ok, r_wreg); end
    wreg_i = 1'b1;
    #1;
    checks++; if (stallreq !== 1'b0 || wreg_o !== 1'b1 || bus_err_o !== 1'b0) begin failures++; $display("FAIL to_idle got %b/%b/%b want 0/1/0", stallreq, wreg_o, bus_err_o); end
  endtask

  task automatic test_reset_busy();
    mem_op_i = 4'd5; mem_addr_i = 32'h0000_0100; wreg_i = 1'b1; mem_ack_i = 1'b0;
    tick();
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL rb_busy got %b want 1", mem_req_o); end
    rst = 1'b1;
    #1;
    checks++; if (wreg_o !== 1'b0 || wdata_o !== 32'h0) begin failures++; $display("FAIL rb_wb got %b/%h want 0/0", wreg_o, wdata_o); end
    tick();
    rst = 1'b0; mem_op_i = 4'd0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    checks++; if (mem_req_o !== 1'b0 || stallreq !== 1'b0) begin failures++; $display("FAIL rb_idle got %b/%b want 0/0", mem_req_o, stallreq); end
    tick();
    mem_ack_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || stallreq !== 1'b0) begin failures++; $display("FAIL rb_late_ack got %b/%b want 0/0", mem_req_o, stallreq); end
    access(4'd5, 32'h0000_0100, 32'h0, 1, 32'h1122_3344);
    checks++; if (r_stalls !== 2 || r_wdata !== 32'h1122_3344) begin failures++; $display("FAIL rb_next got %0d/%h want 2/11223344", r_stalls, r_wdata); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
